hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed EX/MEM1/MEM2 bypass and stall logic.
- Generates forwarding selects for NSRC source operands across DEPTH post-decode stages.
- Generalises load-use and CP0-read stalls into a per-stage "result ready" rule.
- Adds a registered 32-entry scoreboard for long-latency ops (MDU, divider). Sits beside decode; drives the ID operand muxes and the pipeline write enables.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode/pipeline-side bundle for the hazard scoreboard: ID operands, per-stage writeback info, long-op completion, results.
// Latency: none (wires only). Backpressure: the scoreboard answers with stall/issue_ok.
interface hazard_scoreboard_if #(
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int MAX_LONG = 2,
  parameter int SELW     = $clog2(DEPTH+1)
);
  localparam int CW = $clog2(MAX_LONG+1);

  logic                 id_valid;
  logic [NSRC*5-1:0]    id_src;
  logic [NSRC-1:0]      id_src_used;
  logic [4:0]           id_dst;
  logic                 id_long;
  logic [DEPTH-1:0]     stg_wr;
  logic [DEPTH*5-1:0]   stg_rd;
  logic [DEPTH-1:0]     stg_ready;
  logic                 lw_done;
  logic [4:0]           lw_rd;
  logic                 freeze;
  logic                 flush;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall;
  logic                 issue_ok;
  logic [CW-1:0]        pend_cnt;
  logic [31:0]          stall_cycles;
  logic [2:0]           stall_cause;

  modport master (
    output id_valid, id_src, id_src_used, id_dst, id_long,
           stg_wr, stg_rd, stg_ready, lw_done, lw_rd, freeze, flush,
    input  fwd_sel, stall, issue_ok, pend_cnt, stall_cycles, stall_cause
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_dst, id_long,
           stg_wr, stg_rd, stg_ready, lw_done, lw_rd, freeze, flush,
    output fwd_sel, stall, issue_ok, pend_cnt, stall_cycles, stall_cause
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Operand forwarding selects, stall generation and a 32-entry long-latency-op scoreboard for the ID stage.
// Latency: fwd_sel/stall/issue_ok combinational; scoreboard and counters update on the next clk edge.
// Backpressure: stall holds the front end; freeze suppresses stall and issue, flush kills the decode slot.
module hazard_scoreboard #(
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int MAX_LONG = 2,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_LONG+1);

  logic [31:0]          pending_q, pending_d;
  logic [CW-1:0]        pend_cnt_q, pend_cnt_d;
  logic [31:0]          stall_cycles_q, stall_cycles_d;
  logic [2:0]           stall_cause_q, stall_cause_d;

  logic [NSRC*SELW-1:0] fwd_sel;
  logic [SELW-1:0]      sel_v;
  logic                 rdy_v;
  logic [4:0]           src_v;
  logic                 not_ready, raw_long, waw, full;
  logic [2:0]           cause;
  logic                 stall, issue_ok;
  logic                 set_en, set_new, clr_en, clr_eff;

  always_comb begin
    fwd_sel   = '0;
    sel_v     = '0;
    rdy_v     = 1'b1;
    src_v     = '0;
    not_ready = 1'b0;
    raw_long  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      src_v = sb.id_src[5*i +: 5];
      sel_v = '0;
      rdy_v = 1'b1;
      // Walk oldest to youngest so the youngest matching stage wins.
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (sb.stg_wr[k] && (sb.stg_rd[5*k +: 5] != 5'd0) && (sb.stg_rd[5*k +: 5] == src_v)) begin
          sel_v = SELW'(k+1);
          rdy_v = sb.stg_ready[k];
        end
      end
      fwd_sel[i*SELW +: SELW] = sel_v;
      if (sb.id_valid && sb.id_src_used[i]) begin
        if ((sel_v != '0) && !rdy_v) not_ready = 1'b1;
        if (pending_q[src_v])        raw_long  = 1'b1;
      end
    end
  end

  assign waw  = sb.id_valid & pending_q[sb.id_dst];
  assign full = sb.id_valid & sb.id_long & (pend_cnt_q == CW'(MAX_LONG));

  always_comb begin
    cause = 3'd0;
    if      (not_ready) cause = 3'd1;
    else if (raw_long)  cause = 3'd2;
    else if (waw)       cause = 3'd3;
    else if (full)      cause = 3'd4;
  end

  assign stall    = (cause != 3'd0) & ~sb.freeze & ~sb.flush;
  assign issue_ok = sb.id_valid & ~stall & ~sb.freeze & ~sb.flush;

  // Set beats clear on the same register; clears of idle entries are dropped.
  assign set_en  = issue_ok & sb.id_long & (sb.id_dst != 5'd0);
  assign set_new = set_en & ~pending_q[sb.id_dst];
  assign clr_en  = sb.lw_done & (sb.lw_rd != 5'd0) & pending_q[sb.lw_rd];
  assign clr_eff = clr_en & ~(set_en & (sb.id_dst == sb.lw_rd));

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[sb.lw_rd]  = 1'b0;
    if (set_en) pending_d[sb.id_dst] = 1'b1;
    pend_cnt_d = pend_cnt_q + CW'(set_new) - CW'(clr_eff);
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    stall_cause_d = stall ? cause : stall_cause_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      pend_cnt_q     <= '0;
      stall_cycles_q <= '0;
      stall_cause_q  <= '0;
    end else begin
      pending_q      <= pending_d;
      pend_cnt_q     <= pend_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      stall_cause_q  <= stall_cause_d;
    end
  end

  assign sb.fwd_sel      = fwd_sel;
  assign sb.stall        = stall;
  assign sb.issue_ok     = issue_ok;
  assign sb.pend_cnt     = pend_cnt_q;
  assign sb.stall_cycles = stall_cycles_q;
  assign sb.stall_cause  = stall_cause_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NSRC=2, DEPTH=3, MAX_LONG=2) with hand-computed expectations.
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  hazard_scoreboard_if #(.NSRC(2), .DEPTH(3), .MAX_LONG(2)) sb ();

  hazard_scoreboard #(.NSRC(2), .DEPTH(3), .MAX_LONG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    sb.id_valid    = 1'b0;
    sb.id_src      = '0;
    sb.id_src_used = '0;
    sb.id_dst      = '0;
    sb.id_long     = 1'b0;
    sb.stg_wr      = '0;
    sb.stg_rd      = '0;
    sb.stg_ready   = '1;
    sb.lw_done     = 1'b0;
    sb.lw_rd       = '0;
    sb.freeze      = 1'b0;
    sb.flush       = 1'b0;
  endtask

  task automatic set_stg(input int k, input logic wr, input logic [4:0] rd, input logic rdy);
    sb.stg_wr[k]        = wr;
    sb.stg_rd[5*k +: 5] = rd;
    sb.stg_ready[k]     = rdy;
  endtask

  task automatic set_id(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                        input logic [4:0] dst, input logic lng);
    sb.id_valid    = 1'b1;
    sb.id_src      = {s1, s0};
    sb.id_src_used = used;
    sb.id_dst      = dst;
    sb.id_long     = lng;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle();
    #3;
    chk("rst_pend_cnt", 32'(sb.pend_cnt), 0);
    chk("rst_stall_cycles", sb.stall_cycles, 0);
    chk("rst_stall_cause", 32'(sb.stall_cause), 0);
    chk("rst_stall", 32'(sb.stall), 0);
    #5 rst_n = 1'b1;
    step();

    // EX and MEM1 both write r5; youngest (EX) wins. Unused op1 still forwarded from MEM2.
    set_stg(0, 1'b1, 5'd5, 1'b1);
    set_stg(1, 1'b1, 5'd5, 1'b1);
    set_stg(2, 1'b1, 5'd7, 1'b1);
    set_id(5'd5, 5'd7, 2'b01, 5'd10, 1'b0);
    settle();
    chk("fwd0_ex", 32'(sb.fwd_sel[1:0]), 1);
    chk("fwd1_unused", 32'(sb.fwd_sel[3:2]), 3);
    chk("fwd_stall", 32'(sb.stall), 0);
    chk("fwd_issue", 32'(sb.issue_ok), 1);
    step();

    // Register 0 never forwards.
    idle();
    set_stg(0, 1'b1, 5'd0, 1'b1);
    set_id(5'd0, 5'd0, 2'b11, 5'd1, 1'b0);
    settle();
    chk("fwd_r0", 32'(sb.fwd_sel), 0);
    step();

    // Load-use: r8 not ready in EX.
    idle();
    set_stg(0, 1'b1, 5'd8, 1'b0);
    set_id(5'd8, 5'd0, 2'b01, 5'd11, 1'b0);
    settle();
    chk("lu_stall", 32'(sb.stall), 1);
    chk("lu_issue", 32'(sb.issue_ok), 0);
    step();
    chk("lu_cause", 32'(sb.stall_cause), 1);
    chk("lu_cycles", sb.stall_cycles, 1);
    set_stg(0, 1'b0, 5'd0, 1'b1);
    set_stg(1, 1'b1, 5'd8, 1'b1);
    settle();
    chk("lu_fwd_mem1", 32'(sb.fwd_sel[1:0]), 2);
    chk("lu_release", 32'(sb.stall), 0);
    chk("lu_issue2", 32'(sb.issue_ok), 1);
    step();
    chk("lu_cause_hold", 32'(sb.stall_cause), 1);

    // Long op to r3, then RAW on r3 until lw_done r3 has been registered.
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd3, 1'b1);
    settle();
    chk("lo_issue", 32'(sb.issue_ok), 1);
    step();
    chk("lo_cnt1", 32'(sb.pend_cnt), 1);
    set_id(5'd3, 5'd0, 2'b01, 5'd9, 1'b0);
    settle();
    chk("raw_stall", 32'(sb.stall), 1);
    step();
    chk("raw_cause", 32'(sb.stall_cause), 2);
    step();
    sb.lw_done = 1'b1;
    sb.lw_rd   = 5'd3;
    settle();
    chk("raw_done_cycle", 32'(sb.stall), 1);
    step();
    sb.lw_done = 1'b0;
    settle();
    chk("raw_after_done", 32'(sb.stall), 0);
    chk("raw_issue", 32'(sb.issue_ok), 1);
    chk("raw_cnt0", 32'(sb.pend_cnt), 0);
    chk("raw_cycles", sb.stall_cycles, 4);
    step();

    // Full: r1, r2 outstanding, third long op to r4 waits.
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd1, 1'b1);
    step();
    set_id(5'd0, 5'd0, 2'b00, 5'd2, 1'b1);
    step();
    chk("full_cnt2", 32'(sb.pend_cnt), 2);
    set_id(5'd0, 5'd0, 2'b00, 5'd4, 1'b1);
    settle();
    chk("full_stall", 32'(sb.stall), 1);
    step();
    chk("full_cause", 32'(sb.stall_cause), 4);
    sb.lw_done = 1'b1;
    sb.lw_rd   = 5'd1;
    settle();
    chk("full_done_cycle", 32'(sb.stall), 1);
    step();
    sb.lw_done = 1'b0;
    chk("full_cnt_after_clr", 32'(sb.pend_cnt), 1);
    settle();
    chk("full_issue", 32'(sb.issue_ok), 1);
    step();
    chk("full_cnt_again", 32'(sb.pend_cnt), 2);
    chk("full_cycles", sb.stall_cycles, 6);

    // Retire r2; pending = {r4}.
    idle();
    sb.lw_done = 1'b1;
    sb.lw_rd   = 5'd2;
    step();
    chk("clr_r2_cnt", 32'(sb.pend_cnt), 1);

    // Issue long to r6 while a stray lw_done r6 arrives: set wins, no decrement.
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd6, 1'b1);
    sb.lw_done = 1'b1;
    sb.lw_rd   = 5'd6;
    settle();
    chk("same_issue", 32'(sb.issue_ok), 1);
    step();
    chk("same_cnt", 32'(sb.pend_cnt), 2);
    idle();
    set_id(5'd6, 5'd0, 2'b01, 5'd7, 1'b1);
    settle();
    chk("same_r6_pending", 32'(sb.stall), 1);

    // Freeze during that stall; lw_done r4 still retires.
    sb.freeze  = 1'b1;
    sb.lw_done = 1'b1;
    sb.lw_rd   = 5'd4;
    settle();
    chk("frz_stall", 32'(sb.stall), 0);
    chk("frz_issue", 32'(sb.issue_ok), 0);
    step();
    chk("frz_cnt", 32'(sb.pend_cnt), 1);
    chk("frz_cycles", sb.stall_cycles, 6);

    // WAW: ordinary write to pending r6.
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd6, 1'b0);
    settle();
    chk("waw_stall", 32'(sb.stall), 1);
    step();
    chk("waw_cause", 32'(sb.stall_cause), 3);
    chk("waw_cycles", sb.stall_cycles, 7);

    // Build pend_cnt=2, stall_cycles=17, then async reset mid-cycle.
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd9, 1'b1);
    step();
    set_id(5'd9, 5'd0, 2'b01, 5'd12, 1'b0);
    for (int n = 0; n < 10; n++) step();
    chk("pre_rst_cnt", 32'(sb.pend_cnt), 2);
    chk("pre_rst_cycles", sb.stall_cycles, 17);
    settle();
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(sb.pend_cnt), 0);
    chk("arst_cycles", sb.stall_cycles, 0);
    chk("arst_cause", 32'(sb.stall_cause), 0);
    chk("arst_stall", 32'(sb.stall), 0);
    idle();
    #1 rst_n = 1'b1;
    step();

    // Flush with a RAW hazard present: no stall, no issue, no scoreboard set.
    set_id(5'd0, 5'd0, 2'b00, 5'd11, 1'b1);
    step();
    set_id(5'd11, 5'd0, 2'b01, 5'd12, 1'b1);
    sb.flush = 1'b1;
    settle();
    chk("fl_stall", 32'(sb.stall), 0);
    chk("fl_issue", 32'(sb.issue_ok), 0);
    step();
    chk("fl_cnt", 32'(sb.pend_cnt), 1);
    chk("fl_cycles", sb.stall_cycles, 0);
    idle();
    set_id(5'd0, 5'd0, 2'b00, 5'd12, 1'b0);
    settle();
    chk("fl_r12_free", 32'(sb.stall), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
